// File: rtl/gpp_apb_master.sv
// gpp_apb_master: APB initiator turning valid/ready commands into single APB transfers
//
// Accepts one command at a time on the cmd_* port, runs an APB SETUP/ACCESS
// transfer toward the slave, and returns read data plus error status on the
// rsp_* port. Addresses are forced word-aligned on PADDR.
//
// Ports:
//   HCLK, HRESET              clock, asynchronous active-high reset
//   cmd_valid/ready           command handshake
//   cmd_write/addr/wdata      command direction, byte address, write data
//   rsp_valid/ready           response handshake
//   rsp_rdata/err             read data (0 for writes and aborts), error flag
//   PADDR/PWDATA/PWRITE       APB address/data/direction, held between transfers
//   PSEL/PENABLE              APB phase strobes
//   PRDATA/PREADY/PSLVERR     APB slave returns
//
// Build option: define GPP_APB_TIMEOUT_EN to compile in the wait-state
// watchdog that aborts an ACCESS after TIMEOUT_CYCLES PREADY-low cycles.
module gpp_apb_master #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]               cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 || APB_ADDR_WIDTH < 3) begin : g_bad_cfg
        $error("gpp_apb_master: TIMEOUT_CYCLES must be 1..65535 and APB_ADDR_WIDTH >= 3");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                    state_q, state_d;
    logic                      cmd_ready_q;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [31:0]               pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic [31:0]               rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic                      unused_addr_lsbs;

    // Transfers are word-aligned, so the byte-lane address bits are dropped.
    assign unused_addr_lsbs = ^cmd_addr[1:0];

`ifdef GPP_APB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
`ifdef GPP_APB_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            // cmd_ready_q is only ever high in IDLE; it stays low for the
            // first cycle out of reset so the command port opens one edge later.
            IDLE: if (cmd_valid && cmd_ready_q) begin
                state_d  = SETUP;
                paddr_d  = {cmd_addr[APB_ADDR_WIDTH-1:2], 2'b00};
                pwdata_d = cmd_wdata;
                pwrite_d = cmd_write;
            end
            SETUP: begin
                state_d = ACCESS;
`ifdef GPP_APB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ACCESS: if (PREADY) begin
                state_d = RESP;
                rdata_d = pwrite_q ? '0 : PRDATA;
                err_d   = PSLVERR;
            end
`ifdef GPP_APB_TIMEOUT_EN
            else begin
                // Abort on the edge that ends the TIMEOUT_CYCLES-th wait cycle.
                cnt_d = cnt_q + 16'd1;
                if (cnt_d == 16'(TIMEOUT_CYCLES)) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
`endif
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
`ifdef GPP_APB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= state_d == IDLE;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
`ifdef GPP_APB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = state_q == RESP;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWRITE    = pwrite_q;
    assign PSEL      = state_q == SETUP || state_q == ACCESS;
    assign PENABLE   = state_q == ACCESS;
endmodule
